uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_if.sv | 16 +
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/uart_tx.sv | 105 ++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state type and bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    STT_IDLE  = 2'd0,
    STT_START = 2'd1,
    STT_DATA  = 2'd2,
    STT_STOP  = 2'd3
  } tx_state_t;

  // Clocks per serial bit, truncated toward zero.
  function automatic int unsigned calc_pulse_width(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Producer-to-transmitter handshake plus the serial line.
interface uart_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  sig;

  modport tx (
    input  data,
    input  valid,
    output ready,
    output sig
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; flags terminal count while at zero.
module uart_baud_cnt #(
  parameter int unsigned PULSE_WIDTH = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  output logic o_tc_c
);
  localparam int unsigned CNT_W = $clog2(PULSE_WIDTH) + 1;

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so an idle counter keeps reporting terminal count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(PULSE_WIDTH - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == '0);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, stop bit, each one bit period long.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 200_000_000
) (
  input logic clk,
  input logic rstn,
  uart_if.tx  txif
);
  localparam int unsigned PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic                  r_sig;
  logic                  w_sig_nxt;
  logic                  r_ready;
  logic                  w_load;
  logic                  w_tc;

  uart_baud_cnt #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_baud_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_load(w_load),
    .o_tc_c(w_tc)
  );

  // ready is its own flop tracking the next state, so valid never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= STT_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_sig   <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_sig   <= w_sig_nxt;
      r_ready <= (w_state_nxt == STT_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_sig_nxt   = r_sig;
    w_load      = 1'b0;
    case (r_state)
      STT_IDLE: begin
        w_sig_nxt = 1'b1;
        if (txif.valid) begin
          w_shift_nxt = txif.data;
          w_sig_nxt   = 1'b0;
          w_bit_nxt   = '0;
          w_load      = 1'b1;
          w_state_nxt = STT_START;
        end
      end
      STT_START: begin
        if (w_tc) begin
          w_sig_nxt   = r_shift[0];
          w_load      = 1'b1;
          w_state_nxt = STT_DATA;
        end
      end
      STT_DATA: begin
        if (w_tc) begin
          w_shift_nxt = r_shift >> 1;
          w_load      = 1'b1;
          if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
            w_sig_nxt   = 1'b1;
            w_state_nxt = STT_STOP;
          end else begin
            w_sig_nxt = r_shift[1];
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
      STT_STOP: begin
        if (w_tc) begin
          w_state_nxt = STT_IDLE;
        end
      end
      default: begin
        w_state_nxt = STT_IDLE;
        w_sig_nxt   = 1'b1;
      end
    endcase
  end

  assign txif.ready = r_ready;
  assign txif.sig   = r_sig;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 10 clocks per bit: a line monitor decodes frames and checks them.
module tb_uart_tx;
  localparam int unsigned PW = 10;
  localparam int unsigned FRAME = 10 * PW;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  uart_if #(.DATA_WIDTH(8)) txif ();

  uart_tx #(
    .DATA_WIDTH(8),
    .BAUD_RATE (115200),
    .CLK_FREQ  (1_152_000)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .txif(txif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  int         m_phase = 0;
  int         m_cyc = 0;
  logic [9:0] m_bits = '0;
  logic       m_bad = 1'b0;
  int         idle_run = 0;
  int         gap_last = 0;
  int         frames_done = 0;
  logic [9:0] last_frame = '0;
  int         ready_low = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line monitor: samples one point per clock, requires each bit constant for PW cycles.
  always @(negedge clk) begin
    logic [7:0] e;
    int bi;
    if (!rstn) begin
      if (m_phase == 1 && exp_q.size() > 0) e = exp_q.pop_front();
      m_phase  = 0;
      idle_run = 0;
    end else if (m_phase == 0) begin
      if (txif.sig === 1'b0) begin
        m_phase   = 1;
        m_cyc     = 1;
        m_bits    = '0;
        m_bad     = 1'b0;
        gap_last  = idle_run;
      end else begin
        idle_run++;
      end
    end else begin
      bi = m_cyc / PW;
      if (m_cyc % PW == 0) m_bits[bi] = txif.sig;
      else if (txif.sig !== m_bits[bi]) m_bad = 1'b1;
      m_cyc++;
      if (m_cyc == FRAME) begin
        m_phase    = 0;
        idle_run   = 0;
        frames_done++;
        last_frame = m_bits;
        chk("bit_period", 32'(m_bad), 32'd0);
        chk("framing", 32'({m_bits[9], m_bits[0]}), 32'd2);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame got %0h want none", m_bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(m_bits[8:1]), 32'(e));
        end
      end
    end
  end

  // Every ready-low stretch outside reset must last exactly one frame.
  always @(negedge clk) begin
    if (!rstn) begin
      ready_low = 0;
    end else if (txif.ready === 1'b0) begin
      ready_low++;
    end else if (ready_low > 0) begin
      chk("ready_low_len", 32'(ready_low), 32'(FRAME));
      ready_low = 0;
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    int t = 0;
    @(negedge clk);
    txif.data  = d;
    txif.valid = 1'b1;
    while (txif.ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout got ready=%b want 1", txif.ready);
    end
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (!hold) txif.valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_phase != 0 || txif.ready !== 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int f0;
    txif.valid = 1'b0;
    txif.data  = '0;

    // Reset and idle line.
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_sig", 32'(txif.sig), 32'd1);
    chk("reset_ready", 32'(txif.ready), 32'd1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txif.sig !== 1'b1) bad++;
    end
    chk("idle_high", 32'(bad), 32'd0);

    // Single 0xA5 frame against the hand-written line pattern.
    send(8'hA5, 1'b0);
    drain();
    chk("a5_line", 32'(last_frame), 32'(10'b1101001010));

    // Back-to-back with valid held: one idle-high cycle between frames.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    drain();
    chk("b2b_gap", 32'(gap_last), 32'd1);
    chk("b2b_last", 32'(last_frame), 32'(10'b1111111110));

    // Input churn during a frame must not disturb it or cause an extra acceptance.
    f0 = frames_done;
    send(8'h3C, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      txif.data  = 8'hC3;
      txif.valid = i[0];
    end
    txif.valid = 1'b0;
    drain();
    chk("churn_frames", 32'(frames_done - f0), 32'd1);
    chk("churn_line", 32'(last_frame), 32'(10'b1001111000));

    // Reset 45 cycles into a 0x55 frame aborts it.
    f0 = frames_done;
    send(8'h55, 1'b0);
    repeat (44) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("abort_sig", 32'(txif.sig), 32'd1);
    chk("abort_ready", 32'(txif.ready), 32'd1);
    chk("abort_dropped", 32'(exp_q.size()), 32'd0);
    send(8'h81, 1'b0);
    drain();
    chk("after_abort_frames", 32'(frames_done - f0), 32'd1);
    chk("after_abort_line", 32'(last_frame), 32'(10'b1100000010));

    // Random words with random valid gaps.
    f0 = frames_done;
    for (int i = 0; i < 200; i++) begin
      send(8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("rand_frames", 32'(frames_done - f0), 32'd200);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
